tinyalu_param: RTL
==================

Name: tinyalu_param

Overview:
- Parametrised successor to the 8-bit tinyalu.
- Configurable operand width and multiplier latency.
- Adds subtract, an illegal-op error flag and a busy indication.
- Sits behind the same BFM-style start/done handshake and is the DUT for the next testbench generation.

Parameters:
WIDTH, 8, operand width in bits; result is 2*WIDTH.
MUL_LATENCY, 3, cycles from multiply acceptance to done; legal range 1..8.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while busy=0
op  input  3  operation code, captured with the request
A  input  WIDTH  operand A, captured with the request
B  input  WIDTH  operand B, captured with the request
busy  output  1  operation in flight; start ignored while high
done  output  1  one-cycle pulse: result and err are valid
err  output  1  valid with done; 1 = illegal opcode
result  output  2*WIDTH  registered result; held until next done

Behaviour:
- Reset (async assert, sync deassert at clk edge): busy=0, done=0, err=0, result=0, FSM=IDLE, multiply counter=0.
- Opcodes:
  - 000 no_op
  - 001 add: zero-extended A+B
  - 010 and: zero-extended A&B
  - 011 xor: zero-extended A^B
  - 100 mul: full unsigned A*B
  - 101 sub: A-B modulo 2^(2*WIDTH), sign-extended
  - 110 illegal
  - 111 no_op
- Acceptance: start=1 while FSM=IDLE at a rising edge. op, A and B are captured into internal registers at that edge; later input changes have no effect.
- no_op (000, 111): accepted, no done pulse, busy stays 0, result unchanged.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE:
  - add/and/xor/sub/illegal -> EXEC; busy=1 next cycle.
  - mul -> MUL with counter=MUL_LATENCY-1; busy=1.
  - no_op -> stays IDLE.
- EXEC: compute from captured operands -> DONE. result/err register at this edge; done=1 in the following cycle.
  - Net latency: done high exactly 2 cycles after the accept edge for single-cycle ops.
  - Illegal op: result=0, err=1.
- MUL: counter decrements each cycle. At counter=0, result <= A*B and err=0 -> DONE.
  - Net latency: done high MUL_LATENCY+1 cycles after the accept edge.
  - The product may be a pipelined or iterative multiplier, but it must be bit-exact with the stated latency.
- DONE:
  - done=1 for exactly one cycle; busy=1 during DONE.
  - -> IDLE; busy=0 the cycle after done.
  - A new start can be accepted on the first IDLE cycle (back-to-back).
- start while busy=1: ignored completely. No queueing, no error, no effect on the in-flight operation.
- err is meaningful only when done=1; err returns to 0 on the cycle after done.
- result is stable from the done cycle until the next done. Reset clears it.
- Reset mid-operation: in-flight operation discarded, no done pulse, all outputs to reset values immediately (asynchronously).
- start held high continuously: one operation accepted per IDLE visit. A repeat request begins on the cycle after busy falls.
- X/Z on op while start=1 in IDLE: treated as illegal (err=1).

Test Plan:
- WIDTH=8: op=001, A=0xFF, B=0xFF -> result=0x01FE, err=0, done exactly 2 cycles after accept.
- WIDTH=8, MUL_LATENCY=3: op=100, A=0xFF, B=0xFF -> result=0xFE01, done 4 cycles after accept. A second start (op=001, A=1, B=1) pulsed mid-operation produces no extra done.
- WIDTH=8: op=101, A=0x05, B=0x07 -> result=0xFFFE. Then op=011, A=0xA5, B=0x5A back-to-back -> result=0x00FF.
- op=110, A=0x12, B=0x34 -> done with err=1, result=0x0000. Previous result overwritten; err=0 on the following cycle.
- Reset during MUL (2nd busy cycle) -> busy/done/err/result=0 immediately and no done afterwards. Next op=010, A=0xF0, B=0x3C -> result=0x0030.
- WIDTH=16, MUL_LATENCY=1: op=001, A=0xFFFF, B=0x0001 -> result=0x00010000. op=100, A=0xFFFF, B=0xFFFF -> result=0xFFFE0001, done 2 cycles after accept.

Source files
------------

// File: rtl/tinyalu_param.sv
// Parametrised tinyalu: start/done handshake, add/and/xor/sub in two cycles,
// multiply with a configurable latency, illegal-opcode error flag and busy.
module tinyalu_param #(
  parameter int WIDTH       = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = 4;
  localparam int RW = 2 * WIDTH;

  if (MUL_LATENCY < 1 || MUL_LATENCY > 8) begin : g_bad_lat
    $error("tinyalu_param: MUL_LATENCY must be in 1..8");
  end

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_e;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_e        state_q, state_d;
  req_t          req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] result_q, result_d;
  logic          err_q, err_d;
  logic [RW-1:0] a_ext, b_ext;

  assign a_ext = {{WIDTH{1'b0}}, req_q.a};
  assign b_ext = {{WIDTH{1'b0}}, req_q.b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          req_d = '{op: op, a: A, b: B};
          // Unknown opcodes fall to default and are flagged illegal in EXEC.
          case (op)
            3'b000, 3'b111: state_d = IDLE;
            3'b100: begin
              state_d = MUL;
              cnt_d   = CW'(MUL_LATENCY - 1);
            end
            default: state_d = EXEC;
          endcase
        end
      end
      EXEC: begin
        state_d = DONE;
        err_d   = 1'b0;
        case (req_q.op)
          3'b001:  result_d = a_ext + b_ext;
          3'b010:  result_d = a_ext & b_ext;
          3'b011:  result_d = a_ext ^ b_ext;
          3'b101:  result_d = a_ext - b_ext;
          default: begin
            result_d = '0;
            err_d    = 1'b1;
          end
        endcase
      end
      MUL: begin
        if (cnt_q == '0) begin
          result_d = a_ext * b_ext;
          err_d    = 1'b0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // err is qualified by done so it drops the cycle after the pulse.
  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    err    = done & err_q;
    result = result_q;
  end

endmodule
